matrix_calc_pio_in: RTL and testbench
=====================================

# matrix_calc_pio_in

Parametrised Avalon-MM slave input port for the MATRIX_CALCULATOR system. It samples a WIDTH-bit external input through a configurable synchroniser and exposes the synchronised value to the Nios II CPU. It also latches per-bit edge events into an edge-capture register and raises a maskable interrupt. It is the standard input-port block for switches, keys and status lines feeding the matrix engine.

## Interface
- WIDTH, 8: input port width, 1..32.
- SYNC_STAGES, 2: synchroniser depth, 2..4.
- EDGE_TYPE, 0: capture mode. 0 = rising, 1 = falling, 2 = any edge.
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- address  in  2  register select: 0 DATA, 1 reserved, 2 IRQMASK, 3 EDGECAPTURE.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write happens only when chipselect=1 and write_n=0.
- writedata  in  32  write data; only bits [WIDTH-1:0] are used.
- readdata  out  32  registered read data; bits [31:WIDTH] are always 0.
- in_port  in  WIDTH  asynchronous external input.
- irq  out  1  level interrupt, active-high.

## Operation
- Synchroniser: in_port → SYNC_STAGES flops → sync_q. A further register prev_q holds sync_q delayed by 1 clk.
- Edge detect, per bit:
  - EDGE_TYPE 0: rise = sync_q & ~prev_q
  - EDGE_TYPE 1: fall = ~sync_q & prev_q
  - EDGE_TYPE 2: sync_q ^ prev_q
- Priming counter:
  - After reset, a counter runs SYNC_STAGES+1 clks.
  - While the counter is running, edge detect is gated off. This stops an input that is static-high from producing a spurious capture.
  - After the count completes, the counter holds at its terminal value until the next reset.
- EDGECAPTURE (WIDTH bits):
  - A bit is set on a detected edge and stays sticky.
  - A write to address 3 clears each bit where writedata=1 (write-1-to-clear).
  - If set and clear hit the same bit in the same clk, set wins.
- IRQMASK (WIDTH bits): read/write at address 2.
- irq = |(EDGECAPTURE & IRQMASK). It is driven from flops only, so it is glitch-free.
- Read mux, selected by address:
  - 0 → sync_q
  - 1 → 0
  - 2 → IRQMASK
  - 3 → EDGECAPTURE
- readdata is registered every clk from the mux, independent of chipselect. This gives fixed Avalon read latency 1.
- Writes to address 0 or 1 are ignored.
- Reset values: readdata=0, irq=0, IRQMASK=0, EDGECAPTURE=0, sync chain=0, prev_q=0, priming counter=0.

## Timing
- in_port changes and then meets setup before clk edge k:
  - sync_q reflects the change after edge k+SYNC_STAGES-1.
  - The EDGECAPTURE bit sets at edge k+SYNC_STAGES.
  - irq asserts in the same cycle the bit sets, if the bit is masked in.
- Read: readdata is valid 1 clk after address is presented, i.e. it is updated at the edge that samples address.
- A read of address 3 in the same cycle as a clearing write returns the pre-clear value. The cleared value appears on the next read.
- A write to IRQMASK affects irq from the next clk.
- A pulse shorter than 1 clk may be missed; this is acceptable and no capture is guaranteed.
- reset_n assertion mid-operation immediately zeroes all state and outputs. Priming restarts when reset_n deasserts.

## Test plan
- Reset with in_port=8'hFF and SYNC_STAGES=2:
  - read address 0 at cycle 5 → 0x000000FF.
  - EDGECAPTURE stays 0 and irq stays 0.
- Rising edges, EDGE_TYPE=0:
  - IRQMASK=0x01, then in_port 0x00→0x05.
  - 2 clks later EDGECAPTURE=0x05 and irq=1.
  - Write 0x01 to address 3 → EDGECAPTURE=0x04, irq=0.
- Falling edges, EDGE_TYPE=1: in_port 0x0F→0x00 → EDGECAPTURE=0x0F. A following 0x00→0x0F leaves it unchanged.
- Simultaneous set and clear: a new edge on bit 3 in the same clk as a write 0x08 to address 3 → bit 3 remains 1.
- WIDTH=32, EDGE_TYPE=2:
  - in_port toggles 0xFFFFFFFF.
  - EDGECAPTURE=0xFFFFFFFF.
  - Address 1 reads 0.
  - A write to address 0 leaves DATA tracking in_port.
- Reset mid-operation:
  - Assert reset_n while irq=1 → irq, readdata and EDGECAPTURE drop to 0 immediately.
  - After release, there is no capture for SYNC_STAGES+1 clks.

Source files
------------

// File: rtl/matrix_calc_pio_in.sv
// rtl/matrix_calc_pio_in.sv - Avalon-MM input port with synchroniser, edge capture and maskable irq
module matrix_calc_pio_in #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [2:0] PRIME_COUNT = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_chain;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;
    logic [2:0]       prime_cnt;
    logic             primed;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] capture_next;
    logic [WIDTH-1:0] mask_next;
    logic [WIDTH-1:0] clear_bits;
    logic             write_en;
    logic [31:0]      read_mux;

    assign sync_q   = sync_chain[SYNC_STAGES-1];
    assign primed   = (prime_cnt == PRIME_COUNT);
    assign write_en = chipselect & ~write_n;

    // Edge detection stays gated until the chain and prev_q hold real input samples,
    // so a static-high input does not look like an edge right after reset.
    always_comb begin
        edge_det = '0;
        if (primed) begin
            case (EDGE_TYPE)
                0:       edge_det = sync_q & ~prev_q;
                1:       edge_det = ~sync_q & prev_q;
                default: edge_det = sync_q ^ prev_q;
            endcase
        end
    end

    always_comb begin
        clear_bits = '0;
        mask_next  = irq_mask;
        if (write_en && address == 2'd3) begin
            clear_bits = writedata[WIDTH-1:0];
        end
        if (write_en && address == 2'd2) begin
            mask_next = writedata[WIDTH-1:0];
        end
        // A new edge wins over a simultaneous write-1-to-clear.
        capture_next = (edge_capture & ~clear_bits) | edge_det;
    end

    always_comb begin
        read_mux = '0;
        case (address)
            2'd0:    read_mux[WIDTH-1:0] = sync_q;
            2'd2:    read_mux[WIDTH-1:0] = irq_mask;
            2'd3:    read_mux[WIDTH-1:0] = edge_capture;
            default: read_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_chain   <= '0;
            prev_q       <= '0;
            prime_cnt    <= '0;
            edge_capture <= '0;
            irq_mask     <= '0;
            readdata     <= '0;
            irq          <= 1'b0;
        end else begin
            if (SYNC_STAGES > 1) begin
                sync_chain <= {sync_chain[SYNC_STAGES-2:0], in_port};
            end else begin
                sync_chain <= in_port;
            end
            prev_q       <= sync_q;
            if (!primed) begin
                prime_cnt <= prime_cnt + 3'd1;
            end
            edge_capture <= capture_next;
            irq_mask     <= mask_next;
            readdata     <= read_mux;
            // Registered from next-state values so irq rises with the capture bit itself.
            irq          <= |(capture_next & mask_next);
        end
    end

endmodule

// File: tb/tb_matrix_calc_pio_in.sv
// tb/tb_matrix_calc_pio_in.sv - directed bench for matrix_calc_pio_in (rising, falling, any-edge instances)
module tb_matrix_calc_pio_in;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;

    logic [7:0]  in0 = '0;
    logic [7:0]  in1 = '0;
    logic [31:0] in2 = '0;
    logic [31:0] rd0, rd1, rd2;
    logic        irq0, irq1, irq2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    matrix_calc_pio_in #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd0), .in_port(in0), .irq(irq0));

    matrix_calc_pio_in #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd1), .in_port(in1), .irq(irq1));

    matrix_calc_pio_in #(.WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd2), .in_port(in2), .irq(irq2));

    typedef struct {
        logic [7:0] in0;
        logic [7:0] in1;
        logic [7:0] clr;
        logic [7:0] exp_cap0;
        logic [7:0] exp_cap1;
        logic       exp_irq0;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after readdata has been registered.
    task automatic rd(input logic [1:0] a);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        @(negedge clk);
        write_n    = 1'b1;
        chipselect = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{8'h00, 8'h0F, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[1] = '{8'h05, 8'h00, 8'h00, 8'h05, 8'h0F, 1'b1};
        vecs[2] = '{8'h05, 8'h0F, 8'h00, 8'h05, 8'h0F, 1'b1};
        vecs[3] = '{8'h05, 8'h0F, 8'h01, 8'h04, 8'h0E, 1'b0};
        vecs[4] = '{8'h0D, 8'h0F, 8'h00, 8'h0C, 8'h0E, 1'b0};

        // Reset with static-high input on the rising-edge port.
        in0 = 8'hFF; in1 = 8'h0F; in2 = '0;
        idle(3);
        chk("reset_readdata", rd0, 32'h0);
        chk("reset_irq", {31'b0, irq0}, 32'h0);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("data_after_reset", rd0, 32'h0000_00FF);
        rd(2'd3); rd(2'd3);
        chk("no_spurious_cap0", rd0, 32'h0);
        chk("no_spurious_cap1", rd1, 32'h0);
        chk("no_spurious_irq0", {31'b0, irq0}, 32'h0);

        wr(2'd2, 32'h01);
        foreach (vecs[i]) begin
            in0 = vecs[i].in0;
            in1 = vecs[i].in1;
            idle(4);
            if (vecs[i].clr != 8'h00) wr(2'd3, {24'b0, vecs[i].clr});
            rd(2'd3);
            chk($sformatf("vec%0d_cap0", i), rd0, {24'b0, vecs[i].exp_cap0});
            chk($sformatf("vec%0d_cap1", i), rd1, {24'b0, vecs[i].exp_cap1});
            chk($sformatf("vec%0d_irq0", i), {31'b0, irq0}, {31'b0, vecs[i].exp_irq0});
        end

        // Capture latency and set-beats-clear on bit 3.
        wr(2'd3, 32'hFF);
        wr(2'd2, 32'h08);
        rd(2'd2);
        chk("mask_readback", rd0, 32'h08);
        in0 = 8'h05;
        idle(4);
        in0 = 8'h0D;
        idle(2);
        chk("irq_not_yet", {31'b0, irq0}, 32'h0);
        wr(2'd3, 32'h08);
        chk("irq_on_capture", {31'b0, irq0}, 32'h1);
        rd(2'd3);
        chk("set_beats_clear", rd0, 32'h08);
        wr(2'd2, 32'h00);
        chk("mask_off_irq", {31'b0, irq0}, 32'h0);
        wr(2'd2, 32'h08);
        chk("mask_on_irq", {31'b0, irq0}, 32'h1);
        wr(2'd3, 32'h08);
        chk("clear_drops_irq", {31'b0, irq0}, 32'h0);
        rd(2'd3);
        chk("cap_cleared", rd0, 32'h0);

        // Any-edge capture on the 32-bit port.
        in2 = 32'hFFFF_FFFF;
        idle(4);
        rd(2'd3);
        chk("any_edge_rise", rd2, 32'hFFFF_FFFF);
        chk("irq2_masked_in", {31'b0, irq2}, 32'h1);
        rd(2'd1);
        chk("reserved_rd2", rd2, 32'h0);
        chk("reserved_rd0", rd0, 32'h0);
        wr(2'd0, 32'h1234_5678);
        in2 = 32'h0;
        idle(4);
        rd(2'd0);
        chk("data_tracks_in2", rd2, 32'h0);
        chk("data_tracks_in0", rd0, 32'h0000_000D);
        rd(2'd3);
        chk("any_edge_fall", rd2, 32'hFFFF_FFFF);

        // Asynchronous reset mid-operation, then priming with static-high inputs.
        in2 = 32'hFFFF_FFFF; in0 = 8'hFF;
        reset_n = 1'b0;
        #1;
        chk("async_irq2", {31'b0, irq2}, 32'h0);
        chk("async_rd2", rd2, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(8);
        rd(2'd3);
        chk("prime_no_cap2", rd2, 32'h0);
        chk("prime_no_cap0", rd0, 32'h0);
        in2 = 32'h0;
        idle(4);
        rd(2'd3);
        chk("post_prime_cap2", rd2, 32'hFFFF_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
